am_envelope_decoder: RTL

//   Receive-side counterpart of AM_DAC. Samples the 7-bit amplitude-modulated sine stream.

---
 rtl/am_envelope_decoder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/am_envelope_decoder.sv
// rtl/am_envelope_decoder.sv - recovers a distance code from the peak-to-peak swing of an AM sample stream
module am_envelope_decoder #(
  parameter int AM_WIDTH      = 7,
  parameter int WIDTH         = 13,
  parameter int LOG2_MAX_DIST = 11,
  parameter int LOG2_WINDOW   = 7,
  parameter int LOG2_AVG      = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic [AM_WIDTH-1:0] am_in,
  output logic [WIDTH-1:0]    distance_out,
  output logic                distance_valid,
  output logic                busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACQ  = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;

  localparam int ACC_W      = AM_WIDTH + LOG2_AVG;
  localparam int PROD_W     = AM_WIDTH + LOG2_MAX_DIST;
  localparam int LAST_WIN_I = (2 ** LOG2_AVG) - 1;

  localparam logic [LOG2_WINDOW-1:0] LAST_SMP = '1;
  localparam logic [LOG2_AVG:0]      LAST_WIN = LAST_WIN_I[LOG2_AVG:0];

  logic [1:0]             state;
  logic [LOG2_WINDOW-1:0] smp_cnt;
  logic [LOG2_AVG:0]      win_cnt;
  logic [AM_WIDTH-1:0]    max_q;
  logic [AM_WIDTH-1:0]    min_q;
  logic [ACC_W-1:0]       acc;
  logic [AM_WIDTH-1:0]    avg_q;
  logic                   fire;

  logic                   accept;
  logic                   first_smp;
  logic                   win_done;
  logic [AM_WIDTH-1:0]    nmax;
  logic [AM_WIDTH-1:0]    nmin;
  logic [AM_WIDTH-1:0]    p2p;
  logic [ACC_W-1:0]       acc_next;
  logic [AM_WIDTH-1:0]    avg;
  logic [PROD_W-1:0]      scaled;

  assign accept    = (state == S_ACQ) && sample_valid;
  assign first_smp = (smp_cnt == '0);
  assign win_done  = accept && (smp_cnt == LAST_SMP);

  // The window's closing sample is folded into max/min before p2p is taken.
  assign nmax     = (first_smp || (am_in > max_q)) ? am_in : max_q;
  assign nmin     = (first_smp || (am_in < min_q)) ? am_in : min_q;
  assign p2p      = nmax - nmin;
  assign acc_next = acc + ACC_W'(p2p);

  assign avg    = acc[ACC_W-1:LOG2_AVG];
  assign scaled = (PROD_W'(avg_q) << LOG2_MAX_DIST) >> AM_WIDTH;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      smp_cnt <= '0;
      win_cnt <= '0;
      max_q   <= '0;
      min_q   <= '0;
      acc     <= '0;
      avg_q   <= '0;
      fire    <= 1'b0;
    end else if (!enable) begin
      // Abort discards any partial window and the running accumulator.
      state   <= S_IDLE;
      smp_cnt <= '0;
      win_cnt <= '0;
      acc     <= '0;
      fire    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          fire  <= 1'b0;
          state <= S_ACQ;
        end
        S_ACQ: begin
          fire <= 1'b0;
          if (accept) begin
            smp_cnt <= smp_cnt + 1'b1;
            max_q   <= nmax;
            min_q   <= nmin;
            if (win_done) begin
              acc <= acc_next;
              if (win_cnt == LAST_WIN) begin
                win_cnt <= '0;
                state   <= S_CALC;
              end else begin
                win_cnt <= win_cnt + 1'b1;
              end
            end
          end
        end
        S_CALC: begin
          avg_q   <= avg;
          acc     <= '0;
          win_cnt <= '0;
          fire    <= 1'b1;
          state   <= S_ACQ;
        end
        default: begin
          fire  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Result is scaled and published one cycle after CALC latches the average.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      distance_out   <= '0;
      distance_valid <= 1'b0;
    end else begin
      distance_valid <= fire;
      if (fire) distance_out <= WIDTH'(scaled);
    end
  end

endmodule
